// File: rtl/sound_pkg.sv
// Shared types for the sound sequencer: FSM states, sound kinds ordered by
// priority, and the half-period lookup for each kind and note.
package sound_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NOTE1 = 2'd1,
    S_NOTE2 = 2'd2
  } state_t;

  // Encodings increase with priority so arbitration is a plain magnitude compare.
  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_DIR  = 2'd1,
    K_GOOD = 2'd2,
    K_BAD  = 2'd3
  } kind_t;

  // Half-period in cycles for a given kind and note (second = 1 selects note 2).
  function automatic int note_half_period(input kind_t kind, input logic second,
                                          input int good_hp1, input int good_hp2,
                                          input int bad_hp1, input int bad_hp2,
                                          input int dir_hp);
    int hp;
    hp = 0;
    case (kind)
      K_GOOD:  hp = second ? good_hp2 : good_hp1;
      K_BAD:   hp = second ? bad_hp2 : bad_hp1;
      K_DIR:   hp = dir_hp;
      default: hp = 0;
    endcase
    return hp;
  endfunction

endpackage

// File: rtl/sound_sequencer_tone_divider.sv
// Square-wave generator: counts 0..half_period-1 and toggles phase on wrap.
// A restart strobe clears the counter and forces phase high so each note
// begins on its high half.
module tone_divider #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] half_period,
  output logic                 phase
);

  logic [DIV_WIDTH-1:0] div_cnt;

  // Half-period counter and phase flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (restart) begin
      div_cnt <= '0;
      phase   <= 1'b1;
    end else if (div_cnt == half_period - DIV_WIDTH'(1)) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sound_sequencer.sv
// Game-event sound sequencer: edge-detects collision/direction/button inputs,
// arbitrates by priority (BAD > GOOD > DIR) with preemption, plays one or two
// square-wave notes and drives a registered DAC sample with mute gating.
// Optional macro SOUND_DECAY_EN: high level decays by one bit per note quarter.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int DAC_WIDTH    = 8,
  parameter int AMPLITUDE    = 2**(DAC_WIDTH-1),
  parameter int DIV_WIDTH    = 16,
  parameter int DUR_WIDTH    = 16,
  parameter int GOOD_HP1     = 50,
  parameter int GOOD_HP2     = 25,
  parameter int BAD_HP1      = 40,
  parameter int BAD_HP2      = 80,
  parameter int DIR_HP       = 20,
  parameter int NOTE_CYCLES  = 400,
  parameter int CLICK_CYCLES = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 button_i,
  input  logic                 goodColl_i,
  input  logic                 badColl_i,
  input  logic [3:0]           direction_i,
  output logic [DAC_WIDTH-1:0] soundOut
);

  localparam logic [DAC_WIDTH-1:0] AMP        = DAC_WIDTH'(AMPLITUDE);
  localparam logic [DUR_WIDTH-1:0] NOTE_LAST  = DUR_WIDTH'(NOTE_CYCLES - 1);
  localparam logic [DUR_WIDTH-1:0] CLICK_LAST = DUR_WIDTH'(CLICK_CYCLES - 1);

  logic                 button_prev, good_prev, bad_prev;
  logic [3:0]           dir_prev;
  logic                 btn_ev, good_ev, bad_ev, dir_ev;
  kind_t                ev_kind, kind;
  state_t               state;
  logic [DUR_WIDTH-1:0] dur_cnt;
  logic [DIV_WIDTH-1:0] half_period;
  logic                 accept, dur_last, to_note2, restart;
  logic                 mute, phase;
  logic [DAC_WIDTH-1:0] level;

  assign btn_ev  = button_i & ~button_prev;
  assign good_ev = goodColl_i & ~good_prev;
  assign bad_ev  = badColl_i & ~bad_prev;
  assign dir_ev  = (direction_i != dir_prev) && (direction_i != 4'd0);

  // Pick the highest-priority event firing this cycle.
  always_comb begin
    ev_kind = K_NONE;
    if (bad_ev)       ev_kind = K_BAD;
    else if (good_ev) ev_kind = K_GOOD;
    else if (dir_ev)  ev_kind = K_DIR;
  end

  // Lower or equal priority events are dropped while a sound is playing.
  assign accept   = (ev_kind != K_NONE) && ((state == S_IDLE) || (ev_kind > kind));
  assign dur_last = (state != S_IDLE) &&
                    (dur_cnt == ((kind == K_DIR) ? CLICK_LAST : NOTE_LAST));
  assign to_note2 = dur_last && (state == S_NOTE1) && (kind != K_DIR);
  assign restart  = accept || to_note2;

  // Previous-value registers for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      button_prev <= 1'b0;
      good_prev   <= 1'b0;
      bad_prev    <= 1'b0;
      dir_prev    <= 4'd0;
    end else begin
      button_prev <= button_i;
      good_prev   <= goodColl_i;
      bad_prev    <= badColl_i;
      dir_prev    <= direction_i;
    end
  end

  // Sequencer FSM: note selection, duration counting and preemption.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      kind        <= K_NONE;
      dur_cnt     <= '0;
      half_period <= '0;
    end else if (accept) begin
      state       <= S_NOTE1;
      kind        <= ev_kind;
      dur_cnt     <= '0;
      half_period <= DIV_WIDTH'(note_half_period(ev_kind, 1'b0, GOOD_HP1, GOOD_HP2,
                                                 BAD_HP1, BAD_HP2, DIR_HP));
    end else if (state != S_IDLE) begin
      if (to_note2) begin
        state       <= S_NOTE2;
        dur_cnt     <= '0;
        half_period <= DIV_WIDTH'(note_half_period(kind, 1'b1, GOOD_HP1, GOOD_HP2,
                                                   BAD_HP1, BAD_HP2, DIR_HP));
      end else if (dur_last) begin
        state   <= S_IDLE;
        kind    <= K_NONE;
        dur_cnt <= '0;
      end else begin
        dur_cnt <= dur_cnt + DUR_WIDTH'(1);
      end
    end
  end

  tone_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tone_divider (
    .clk         (clk),
    .rst         (rst),
    .restart     (restart),
    .half_period (half_period),
    .phase       (phase)
  );

`ifdef SOUND_DECAY_EN
  function automatic logic [DAC_WIDTH-1:0] decay_level(input logic [1:0] quarter);
    return AMP >> quarter;
  endfunction

  logic [DUR_WIDTH-1:0] q1_bound, q2_bound, q3_bound;
  logic [1:0]           quarter;

  // Quarter of the current note from elaboration-time boundaries.
  always_comb begin
    q1_bound = DUR_WIDTH'(NOTE_CYCLES / 4);
    q2_bound = DUR_WIDTH'(NOTE_CYCLES / 2);
    q3_bound = DUR_WIDTH'((3 * NOTE_CYCLES) / 4);
    if (kind == K_DIR) begin
      q1_bound = DUR_WIDTH'(CLICK_CYCLES / 4);
      q2_bound = DUR_WIDTH'(CLICK_CYCLES / 2);
      q3_bound = DUR_WIDTH'((3 * CLICK_CYCLES) / 4);
    end
    quarter = 2'd0;
    if (dur_cnt >= q3_bound)      quarter = 2'd3;
    else if (dur_cnt >= q2_bound) quarter = 2'd2;
    else if (dur_cnt >= q1_bound) quarter = 2'd1;
    level = decay_level(quarter);
  end
`else
  assign level = AMP;
`endif

  // Mute toggles on each button press; it gates only the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mute <= 1'b0;
    else if (btn_ev) mute <= ~mute;
  end

  // Registered DAC sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) soundOut <= '0;
    else if ((state != S_IDLE) && phase && !mute) soundOut <= level;
    else soundOut <= '0;
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with default parameters. Expected DAC
// samples are queued per cycle when stimulus is planned, and popped/compared
// on each falling edge.
module tb_sound_sequencer;

  logic       tb_clk = 1'b0;
  logic       rst = 1'b1;
  logic       button_i = 1'b0;
  logic       goodColl_i = 1'b0;
  logic       badColl_i = 1'b0;
  logic [3:0] direction_i = 4'd0;
  logic [7:0] soundOut;

  int         checks = 0;
  int         errors = 0;
  int         sample_n = 0;
  string      tag = "init";
  logic [7:0] exp_q[$];

  always #5 tb_clk = ~tb_clk;

  sound_sequencer dut (
    .clk         (tb_clk),
    .rst         (rst),
    .button_i    (button_i),
    .goodColl_i  (goodColl_i),
    .badColl_i   (badColl_i),
    .direction_i (direction_i),
    .soundOut    (soundOut)
  );

  // Expected sample s after the trigger-detecting edge (s = 0 is that edge).
  function automatic logic [7:0] seq_val(input int hp1, input int hp2, input int dur,
                                         input int s);
    int i, hp, q, last;
    last = (hp2 > 0) ? 2 * dur : dur;
    if (s < 1 || s > last) return 8'd0;
    i  = s - 1;
    hp = hp1;
    if (i >= dur) begin
      i  = i - dur;
      hp = hp2;
    end
    if (((i / hp) % 2) != 0) return 8'd0;
    q = 0;
`ifdef SOUND_DECAY_EN
    q = i / (dur / 4);
`endif
    return 8'(128 >> q);
  endfunction

  task automatic push_seq(input int hp1, input int hp2, input int dur,
                          input int first, input int last, input int mlo, input int mhi);
    logic [7:0] v;
    for (int s = first; s < last; s++) begin
      v = seq_val(hp1, hp2, dur, s);
      if (s >= mlo && s < mhi) v = 8'd0;
      exp_q.push_back(v);
    end
  endtask

  task automatic push_zero(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(8'd0);
  endtask

  task automatic step();
    logic [7:0] exp_v;
    @(negedge tb_clk);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s sample %0d: scoreboard empty, soundOut=%0d", tag, sample_n, soundOut);
    end else begin
      exp_v = exp_q.pop_front();
      assert (soundOut === exp_v) else begin
        errors++;
        $error("FAIL %s sample %0d: soundOut=%0d expected %0d", tag, sample_n, soundOut, exp_v);
      end
    end
    sample_n++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic direct_zero(input string name);
    checks++;
    assert (soundOut === 8'd0) else begin
      errors++;
      $error("FAIL %s: soundOut=%0d expected 0", name, soundOut);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(negedge tb_clk); direct_zero("reset_hold_a");
    @(negedge tb_clk); direct_zero("reset_hold_b");
    rst = 1'b0;
    tag = "idle"; push_zero(3); steps(3);

    // Asynchronous reset in the middle of a tone
    tag = "pre_reset";
    goodColl_i = 1'b1;
    push_seq(50, 25, 400, 0, 12, 0, 0);
    for (int s = 0; s < 12; s++) begin
      if (s == 5) goodColl_i = 1'b0;
      step();
    end
    #2 rst = 1'b1;
    #1 direct_zero("rst_async");
    @(negedge tb_clk); direct_zero("rst_held_1");
    @(negedge tb_clk); direct_zero("rst_held_2");
    rst = 1'b0;
    tag = "post_reset"; push_zero(20); steps(20);

    // Good collision: rising chirp, single trigger
    tag = "good";
    goodColl_i = 1'b1;
    push_seq(50, 25, 400, 0, 811, 0, 0);
    for (int s = 0; s < 811; s++) begin
      if (s == 5) goodColl_i = 1'b0;
      step();
    end

    // Bad collision preempts a good note 1
    tag = "preempt";
    goodColl_i = 1'b1;
    push_seq(50, 25, 400, 0, 121, 0, 0);
    push_seq(40, 80, 400, 1, 811, 0, 0);
    for (int s = 0; s < 931; s++) begin
      if (s == 5)   goodColl_i = 1'b0;
      if (s == 120) badColl_i = 1'b1;
      if (s == 125) badColl_i = 1'b0;
      step();
    end

    // Direction changes ignored during BAD
    tag = "dir_during_bad";
    badColl_i = 1'b1;
    push_seq(40, 80, 400, 0, 811, 0, 0);
    for (int s = 0; s < 811; s++) begin
      if (s == 5)   badColl_i = 1'b0;
      if (s == 200) direction_i = 4'b0001;
      if (s == 300) direction_i = 4'b0010;
      step();
    end

    // Direction click from idle, then change to zero gives nothing
    tag = "dir_click";
    direction_i = 4'b0100;
    push_seq(20, 0, 100, 0, 111, 0, 0);
    steps(111);
    tag = "dir_zero";
    direction_i = 4'b0000;
    push_zero(30); steps(30);

    // Simultaneous good and bad: BAD wins; held inputs do not retrigger
    tag = "simultaneous";
    goodColl_i = 1'b1;
    badColl_i  = 1'b1;
    push_seq(40, 80, 400, 0, 831, 0, 0);
    steps(831);
    goodColl_i = 1'b0;
    badColl_i  = 1'b0;
    tag = "held_release"; push_zero(5); steps(5);

    // Mute mid-sequence, unmute in note 2 with the tone still in phase
    tag = "mute";
    goodColl_i = 1'b1;
    push_seq(50, 25, 400, 0, 811, 151, 601);
    for (int s = 0; s < 811; s++) begin
      if (s == 5)   goodColl_i = 1'b0;
      if (s == 150) button_i = 1'b1;
      if (s == 153) button_i = 1'b0;
      if (s == 600) button_i = 1'b1;
      if (s == 603) button_i = 1'b0;
      step();
    end

    // Good preempts a click; a second good during GOOD is dropped
    tag = "dir_preempted";
    direction_i = 4'b0001;
    push_seq(20, 0, 100, 0, 31, 0, 0);
    push_seq(50, 25, 400, 1, 811, 0, 0);
    for (int s = 0; s < 841; s++) begin
      if (s == 30)  goodColl_i = 1'b1;
      if (s == 35)  goodColl_i = 1'b0;
      if (s == 230) goodColl_i = 1'b1;
      if (s == 235) goodColl_i = 1'b0;
      step();
    end

    checks++;
    assert (exp_q.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Parametrised successor to the single-tone sound generator. Game events are turned into short tone sequences of one or two square-wave notes: a rising two-note chirp for a good collision, a falling two-note tone for a bad collision, and a short click on a direction change. Events are arbitrated by priority, and a button toggles mute. The block sits between the game-logic event outputs and the DAC driver, and its `soundOut` feeds the DAC directly.

## Interface
Parameters:
- `DAC_WIDTH`, 8, width of `soundOut`.
- `AMPLITUDE`, 2**(DAC_WIDTH-1), value driven on the high phase of the square wave.
- `DIV_WIDTH`, 16, width of the half-period counter.
- `DUR_WIDTH`, 16, width of the note-duration counter.
- `GOOD_HP1`, 50 / `GOOD_HP2`, 25, half-periods in cycles of the good-collision notes 1 and 2.
- `BAD_HP1`, 40 / `BAD_HP2`, 80, half-periods in cycles of the bad-collision notes 1 and 2.
- `DIR_HP`, 20, half-period in cycles of the direction click.
- `NOTE_CYCLES`, 400, duration in cycles of each collision note.
- `CLICK_CYCLES`, 100, duration in cycles of the click.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `button_i`  in  1  mute toggle; a rising edge toggles mute.
- `goodColl_i`  in  1  good-collision event; rising-edge triggered.
- `badColl_i`  in  1  bad-collision event; rising-edge triggered.
- `direction_i`  in  4  one-hot direction; any change to a nonzero value triggers a click.
- `soundOut`  out  DAC_WIDTH  DAC sample.

## Operation
- **Input registers.** Every input is registered once for edge detection, giving `prev` values.
  - Collision and button events fire when the current value is 1 and `prev` is 0.
  - A direction event fires when `direction_i != prev` and `direction_i != 0`.
- **States.** IDLE, NOTE1, NOTE2. The current sound kind is one of NONE, DIR, GOOD, BAD, with priority BAD > GOOD > DIR.
- **Trigger acceptance.**
  - If several events fire in the same cycle, the highest priority wins.
  - An event is accepted when the block is in IDLE, or when its priority is strictly greater than the current kind (preemption).
  - Events of equal or lower priority arriving while playing are dropped, not queued.
- **On accept.**
  - State goes to NOTE1 and kind is set to the event.
  - The divider and duration counters clear.
  - Phase is set to 1.
  - The half-period loads from the event's note-1 parameter.
- **Tone generation.**
  - The divider counts 0..HP-1. On reaching HP-1 it wraps to 0 and phase toggles.
  - Result: a square wave of period 2·HP cycles, 50% duty.
- **Duration.** The duration counter counts 0..D-1, where D = NOTE_CYCLES for GOOD/BAD and CLICK_CYCLES for DIR. On reaching D-1:
  - GOOD/BAD in NOTE1 go to NOTE2, with counters cleared, phase set to 1 and HP set to note 2.
  - NOTE2, or DIR in NOTE1, goes to IDLE with kind NONE.
- **Output.**
  - `soundOut` is registered: AMPLITUDE when not IDLE, phase = 1 and not muted; otherwise 0.
  - Mute gates only the output. The sequencer keeps running while muted.
- **Reset values.**
  - State IDLE, kind NONE.
  - Counters, phase and `prev` values are 0; mute is 0.
  - `soundOut` is 0.
- **Reset mid-sequence** aborts immediately: `soundOut` goes to 0 asynchronously.

## Timing
- An event is detected at posedge k, which is the first edge sampling the input high with `prev` low. The state is NOTE1 after edge k, and `soundOut` equals AMPLITUDE after edge k+1.
- The first phase toggle is HP cycles after entry. `soundOut` follows each phase change with 1 cycle of lag.
- A GOOD or BAD sequence occupies exactly 2·NOTE_CYCLES cycles. A DIR click occupies CLICK_CYCLES cycles.
- `soundOut` returns to 0 one cycle after the state reaches IDLE.
- Preemption takes effect at the detecting edge. There is no gap cycle beyond the output register.
- A button edge toggles mute at the detecting edge, and `soundOut` reflects it 1 cycle later.
- Holding an input high does not retrigger.

## Configuration
- **`SOUND_DECAY_EN` defined:** the high-phase amplitude is `AMPLITUDE >> q`, where q ∈ {0,1,2,3} is the current quarter of the note.
  - Quarter boundaries are compared against constants D/4, D/2 and 3D/4 computed at elaboration; no divider is built.
- **`SOUND_DECAY_EN` undefined:** the amplitude stays constant at AMPLITUDE.

## Structure
- **Package `sound_pkg`:** the state enum (IDLE/NOTE1/NOTE2), the kind enum (NONE/DIR/GOOD/BAD) with encodings ordered by priority, and a function returning the half-period for a given kind and note.
- **Sub-module `tone_divider`:** the half-period counter plus phase flop, with inputs `clk`, `rst`, a restart strobe and `half_period`, and output `phase`.
- **Top level:** edge detection, arbitration, duration counter, FSM, mute and output register.

## Test plan
1. Assert `rst` between edges → `soundOut` = 0 immediately. Hold `rst` over 2 edges → `soundOut` stays 0. Release `rst` → `soundOut` stays 0.
2. Pulse `goodColl_i` for 5 cycles (defaults) → `soundOut` toggles 128/0 every 50 cycles for 400 cycles, then every 25 cycles for 400 cycles, then holds 0. Total 800 cycles and a single trigger.
3. While `goodColl_i` is mid-NOTE1, pulse `badColl_i` → the next cycle restarts at a 40-cycle half-period; the full 800-cycle BAD sequence follows and 0 after.
4. Change `direction_i` from 0001 to 0010 during a BAD sequence → ignored. From IDLE → 100 cycles of tone with 20-cycle half-periods. Change from 0010 to 0000 → no click.
5. Raise `goodColl_i` and `badColl_i` on the same cycle → the BAD sequence plays.
6. Press `button_i` mid-sequence → `soundOut` = 0 while the FSM continues. Press again before the sequence ends → tone resumes at the correct phase. With `SOUND_DECAY_EN` defined, the high level across a note is 128, 64, 32 and 16 in successive 100-cycle quarters.
